// File: rtl/icache_pkg.sv
// Shared types, constants and helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ALLOCATE = 2'd1,
        FILLED   = 2'd2
    } state_t;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int MEM_ADDR_W      = 28;
    localparam int BLOCK_W         = 128;

    // Pick one 32-bit word out of a block; word k lives at bits [32k+31:32k].
    function automatic logic [31:0] word_sel(input logic [BLOCK_W-1:0] block,
                                             input logic [1:0]         offset);
        return block[{offset, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Pipeline-side and memory-side signals of the instruction cache.
// Handshake: the pipeline holds proc_read/proc_addr and treats the fetch as
// accepted in the first cycle proc_stall is low. mem_read is held high with
// a stable mem_addr until memory answers with a single-cycle mem_ready pulse,
// during which mem_rdata carries the whole block.
interface icache_direct_mapped_if;
    import icache_pkg::*;

    logic                  proc_read;
    logic                  proc_write;
    logic [29:0]           proc_addr;
    logic [31:0]           proc_wdata;
    logic                  proc_stall;
    logic [31:0]           proc_rdata;
    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [BLOCK_W-1:0]    mem_wdata;
    logic                  mem_ready;
    logic [BLOCK_W-1:0]    mem_rdata;

    // Cache side.
    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    // Environment side: pipeline plus instruction memory.
    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_ready, mem_rdata,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port, one synchronous write port.
// Only the valid bits are reset; tag and data contents are don't-care until valid.
module icache_array
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = 3,
    parameter int TAG_W      = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [BLOCK_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [BLOCK_W-1:0] wr_data
);

    logic [NUM_BLOCKS-1:0] valid;
    logic [TAG_W-1:0]      tags  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    blocks[NUM_BLOCKS];

    // Valid bits: cleared by reset, set when a line is installed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, written on line install only.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]   <= wr_tag;
            blocks[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = blocks[rd_idx];

endmodule

// File: rtl/icache_direct_mapped.sv
// Read-only direct-mapped instruction cache with a 4-word block refill.
// Optional macro ICACHE_PERF_EN adds saturating hit/miss counter outputs.
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter  int NUM_BLOCKS = 8,
    localparam int IDX_W      = $clog2(NUM_BLOCKS),
    localparam int TAG_W      = 28 - IDX_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    icache_direct_mapped_if.slave  bus,
    output state_t                 state_dbg
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
`endif
);

    state_t                state;
    state_t                state_nx;
    logic [MEM_ADDR_W-1:0] miss_addr;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [BLOCK_W-1:0]    line_data;
    logic                  hit;
    logic                  miss_start;
    logic                  fill_en;
    logic                  stall;
    logic [31:0]           rdata;

    assign req_idx = bus.proc_addr[IDX_W+1:2];
    assign req_tag = bus.proc_addr[29:IDX_W+2];

    icache_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (req_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (fill_en),
        .wr_idx   (miss_addr[IDX_W-1:0]),
        .wr_tag   (miss_addr[MEM_ADDR_W-1:IDX_W]),
        .wr_data  (bus.mem_rdata)
    );

    // A write request is simply a read when proc_read is also set; otherwise ignored.
    assign hit        = bus.proc_read && line_valid && (line_tag == req_tag);
    assign miss_start = (state == IDLE) && bus.proc_read && !hit;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Latch the block address of a miss; memory sees it for the whole refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_addr <= '0;
        end else if (miss_start) begin
            miss_addr <= bus.proc_addr[29:2];
        end
    end

    // Next-state, stall, read data and line install.
    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        rdata    = '0;
        fill_en  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.proc_read) begin
                    if (hit) begin
                        rdata = word_sel(line_data, bus.proc_addr[1:0]);
                    end else begin
                        stall    = 1'b1;
                        state_nx = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                stall = 1'b1;
                if (bus.mem_ready) begin
                    fill_en  = 1'b1;
                    state_nx = FILLED;
                end
            end
            FILLED: begin
                // One settling cycle so the re-evaluated fetch hits from registered state.
                stall    = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.proc_stall = stall;
    assign bus.proc_rdata = rdata;
    assign bus.mem_read   = (state == ALLOCATE);
    assign bus.mem_addr   = miss_addr;
    assign bus.mem_write  = 1'b0;
    assign bus.mem_wdata  = '0;
    assign state_dbg      = state;

    logic unused_inputs;
    assign unused_inputs = ^{bus.proc_write, bus.proc_wdata};

`ifdef ICACHE_PERF_EN
    // Saturating hit counter: one count per IDLE cycle that serves a fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if ((state == IDLE) && hit && (hit_cnt != 32'hFFFF_FFFF)) begin
            hit_cnt <= hit_cnt + 32'd1;
        end
    end

    // Saturating miss counter: one count per refill started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt <= '0;
        end else if (miss_start && (miss_cnt != 32'hFFFF_FFFF)) begin
            miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped (NUM_BLOCKS=8).
// Build with ICACHE_PERF_EN defined to also check the hit/miss counters.
module tb_icache_direct_mapped;
    import icache_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    state_t state_dbg;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    icache_direct_mapped_if bus ();

    icache_direct_mapped #(.NUM_BLOCKS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    int vectors;
    int miscompares;

    // Cache contents as the fetch rules dictate: 8 lines, index addr[4:2], tag addr[29:5].
    logic         mdl_valid[8];
    logic [24:0]  mdl_tag[8];
    logic [127:0] mdl_data[8];
    int           mdl_hits;
    int           mdl_misses;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit mdl_is_hit(input logic [29:0] a);
        return mdl_valid[a[4:2]] && (mdl_tag[a[4:2]] == a[29:5]);
    endfunction

    function automatic logic [31:0] mdl_word(input logic [29:0] a);
        logic [127:0] b;
        b = mdl_data[a[4:2]];
        return b[int'(a[1:0]) * 32 +: 32];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl_valid[i] = 1'b0;
        mdl_hits   = 0;
        mdl_misses = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Full miss sequence for address a. During the refill the pipeline drives
    // a_late (or random garbage when wander is set); memory answers after lat
    // ALLOCATE cycles. When a_late==a the post-fill hit cycle is checked too.
    task automatic do_miss(input logic [29:0] a, input logic [29:0] a_late,
                           input logic [127:0] blk, input int lat, input bit wander);
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = a;
        settle();
        check("miss_stall", bus.proc_stall, 1'b1);
        check("miss_no_early_mem_read", bus.mem_read, 1'b0);
        mdl_misses++;
        tick();
        for (int i = 0; i < lat; i++) begin
            if (wander) begin
                bus.proc_read  = 1'($urandom_range(0, 1));
                bus.proc_write = 1'($urandom_range(0, 1));
                bus.proc_addr  = 30'($urandom);
            end else begin
                bus.proc_addr = a_late;
            end
            settle();
            check("alloc_mem_read", bus.mem_read, 1'b1);
            check("alloc_mem_addr", bus.mem_addr, a[29:2]);
            check("alloc_stall", bus.proc_stall, 1'b1);
            tick();
        end
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = a_late;
        bus.mem_ready  = 1'b1;
        bus.mem_rdata  = blk;
        settle();
        check("ready_mem_read", bus.mem_read, 1'b1);
        check("ready_mem_addr", bus.mem_addr, a[29:2]);
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = {4{$urandom}};
        mdl_valid[a[4:2]] = 1'b1;
        mdl_tag[a[4:2]]   = a[29:5];
        mdl_data[a[4:2]]  = blk;
        settle();
        check("filled_stall", bus.proc_stall, 1'b1);
        check("filled_mem_read", bus.mem_read, 1'b0);
        tick();
        if (a_late == a) begin
            settle();
            check("post_fill_stall", bus.proc_stall, 1'b0);
            check("post_fill_rdata", bus.proc_rdata, mdl_word(a));
            mdl_hits++;
            tick();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic        exp_stall;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[7];

    // ---------------- main test ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        mdl_reset();

        tbl[0] = '{1'b1, 1'b0, 30'h11, 1'b0, 32'hB};
        tbl[1] = '{1'b1, 1'b0, 30'h12, 1'b0, 32'hC};
        tbl[2] = '{1'b1, 1'b0, 30'h13, 1'b0, 32'hD};
        tbl[3] = '{1'b0, 1'b1, 30'h10, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 30'h13, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b1, 30'h12, 1'b0, 32'hC};
        tbl[6] = '{1'b1, 1'b0, 30'h10, 1'b0, 32'hA};

        rst_n          = 1'b0;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_state", state_dbg, IDLE);
        check("rst_stall", bus.proc_stall, 1'b0);
        check("rst_rdata", bus.proc_rdata, 32'h0);
        check("rst_mem_read", bus.mem_read, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 28'h0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_wdata", bus.mem_wdata, 128'h0);
`ifdef ICACHE_PERF_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Cold miss on 0x10, memory answers after 3 cycles
        do_miss(30'h10, 30'h10, {32'hD, 32'hC, 32'hB, 32'hA}, 3, 1'b0);

        // Same-block hits and idle/write-only cycles from the table
        for (int i = 0; i < 7; i++) begin
            bus.proc_read  = tbl[i].rd;
            bus.proc_write = tbl[i].wr;
            bus.proc_addr  = tbl[i].addr;
            bus.proc_wdata = $urandom;
            settle();
            check($sformatf("tbl%0d_stall", i), bus.proc_stall, tbl[i].exp_stall);
            check($sformatf("tbl%0d_rdata", i), bus.proc_rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_mem_read", i), bus.mem_read, 1'b0);
            if (tbl[i].rd) mdl_hits++;
            tick();
`ifdef ICACHE_PERF_EN
            if (i == 2) begin
                check("perf_hit_cnt_4", hit_cnt, 32'd4);
                check("perf_miss_cnt_1", miss_cnt, 32'd1);
            end
`endif
        end

        // Conflict eviction: 0x30 shares index with 0x10, then 0x10 misses again
        do_miss(30'h30, 30'h30, {4{$urandom}}, 2, 1'b0);
        do_miss(30'h10, 30'h10, {32'hD, 32'hC, 32'hB, 32'hA}, 1, 1'b0);

        // Address change mid-refill: block 0x8 fills, then 0x40 misses to block 0x10
        do_miss(30'h20, 30'h40, {4{$urandom}}, 2, 1'b0);
        do_miss(30'h40, 30'h40, {4{$urandom}}, 0, 1'b0);

        // Reset in the middle of a refill
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h50;
        settle();
        check("rmid_miss_stall", bus.proc_stall, 1'b1);
        tick();
        settle();
        check("rmid_alloc_mem_read", bus.mem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rmid_mem_read_drop", bus.mem_read, 1'b0);
        check("rmid_mem_addr", bus.mem_addr, 28'h0);
        check("rmid_state", state_dbg, IDLE);
        mdl_reset();
        tick();
        rst_n         = 1'b1;
        bus.proc_read = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {4{$urandom}};
        settle();
        check("late_ready_stall", bus.proc_stall, 1'b0);
        check("late_ready_rdata", bus.proc_rdata, 32'h0);
        tick();
        bus.mem_ready = 1'b0;
        settle();
        check("late_ready_no_alloc", bus.mem_read, 1'b0);
        tick();
        do_miss(30'h50, 30'h50, {4{$urandom}}, 2, 1'b0);

        // Randomized fetches against the reference model
        for (int n = 0; n < 200; n++) begin
            logic [29:0] a;
            a = {23'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            a = {a[29:5] & 25'h3, a[4:0]};
            if ($urandom_range(0, 9) == 0) begin
                bus.proc_read  = 1'b0;
                bus.proc_write = 1'($urandom_range(0, 1));
                bus.proc_addr  = a;
                bus.mem_ready  = 1'($urandom_range(0, 1));
                bus.mem_rdata  = {4{$urandom}};
                settle();
                check("rnd_idle_stall", bus.proc_stall, 1'b0);
                check("rnd_idle_rdata", bus.proc_rdata, 32'h0);
                check("rnd_idle_mem_read", bus.mem_read, 1'b0);
                tick();
                bus.mem_ready = 1'b0;
            end else if (mdl_is_hit(a)) begin
                bus.proc_read  = 1'b1;
                bus.proc_write = 1'($urandom_range(0, 1));
                bus.proc_addr  = a;
                settle();
                check("rnd_hit_stall", bus.proc_stall, 1'b0);
                check("rnd_hit_rdata", bus.proc_rdata, mdl_word(a));
                mdl_hits++;
                tick();
            end else begin
                do_miss(a, a, {4{$urandom}}, $urandom_range(0, 4), 1'b1);
            end
        end

`ifdef ICACHE_PERF_EN
        check("final_hit_cnt", hit_cnt, 32'(mdl_hits));
        check("final_miss_cnt", miss_cnt, 32'(mdl_misses));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
